// File: rtl/result_frame_writer.sv
// Captures saturated convolution results into a frame RAM, then streams the frame out.
// Build option: define ABS_MAG_EN to store |x| for negative results instead of clamping to 0.
module result_frame_writer #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned IN_W       = 17,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned NUM_PIXELS = 65536
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              result,
  input  logic [IN_W-1:0]   output_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  input  logic              readout_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_data,
  output logic              out_last,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0]       LastAddr = ADDR_W'(NUM_PIXELS - 1);
  localparam logic signed [IN_W:0]    PixMax   = (IN_W + 1)'((2 ** PIX_W) - 1);

  typedef enum logic [1:0] {StCapture, StFull, StReadout} state_e;

  function automatic logic [PIX_W-1:0] convert(input logic [IN_W-1:0] v);
    logic signed [IN_W:0] s;
    logic [PIX_W-1:0]     r;
    s = {v[IN_W-1], v};
`ifdef ABS_MAG_EN
    if (s < 0) s = -s;
`endif
    if (s < 0)           r = '0;
    else if (s > PixMax) r = '1;
    else                 r = s[PIX_W-1:0];
    return r;
  endfunction

  state_e             state_q;
  logic [ADDR_W-1:0]  wcnt_q;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [PIX_W-1:0]   wr_data_q;
  logic               frame_done_q;
  logic               overrun_q;

  logic [ADDR_W-1:0]  raddr_q;
  logic               rd_done_q;
  logic               pend_q;
  logic               pend_last_q;
  logic [PIX_W-1:0]   buf_data_q [2];
  logic               buf_last_q [2];
  logic               hd_q;
  logic [1:0]         occ_q;

  logic               pop;
  logic               wr_idx;
  logic [1:0]         occ_eff;
  logic               rd_en_c;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf_data_q[hd_q];
  assign out_last  = out_valid & buf_last_q[hd_q];

  // Read issue looks at this cycle's pop so a 2-entry buffer still sustains 1 pixel/cycle.
  always_comb begin
    pop     = out_valid & out_ready;
    wr_idx  = hd_q ^ occ_q[0];
    occ_eff = occ_q + {1'b0, pend_q} - {1'b0, pop};
    rd_en_c = (state_q == StReadout) && !rd_done_q && (occ_eff < 2'd2);
  end

  assign rd_en      = rd_en_c;
  assign rd_addr    = raddr_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= StCapture;
      wcnt_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      raddr_q       <= '0;
      rd_done_q     <= 1'b0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q[0] <= 1'b0;
      buf_last_q[1] <= 1'b0;
      hd_q          <= 1'b0;
      occ_q         <= 2'd0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;

      if (result) begin
        if (state_q == StCapture) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= wcnt_q;
          wr_data_q <= convert(output_result);
          if (wcnt_q == LastAddr) begin
            frame_done_q <= 1'b1;
            wcnt_q       <= '0;
            state_q      <= StFull;
          end else begin
            wcnt_q <= wcnt_q + ADDR_W'(1);
          end
        end else begin
          overrun_q <= 1'b1;
        end
      end

      // rd_data is valid the cycle after rd_en; pend_q marks that cycle.
      pend_q      <= rd_en_c;
      pend_last_q <= (raddr_q == LastAddr);
      if (rd_en_c) begin
        if (raddr_q == LastAddr) begin
          rd_done_q <= 1'b1;
          raddr_q   <= '0;
        end else begin
          raddr_q <= raddr_q + ADDR_W'(1);
        end
      end

      if (pend_q) begin
        buf_data_q[wr_idx] <= rd_data;
        buf_last_q[wr_idx] <= pend_last_q;
      end
      occ_q <= occ_q + {1'b0, pend_q} - {1'b0, pop};
      if (pop) hd_q <= ~hd_q;

      case (state_q)
        StFull: begin
          if (readout_start) begin
            state_q   <= StReadout;
            raddr_q   <= '0;
            rd_done_q <= 1'b0;
          end
        end
        StReadout: begin
          if (pop && out_last) begin
            state_q   <= StCapture;
            wcnt_q    <= '0;
            raddr_q   <= '0;
            rd_done_q <= 1'b0;
            occ_q     <= 2'd0;
            hd_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_frame_writer.sv
// Bench for result_frame_writer on a reduced 1024-pixel frame with a behavioural frame RAM.
module tb_result_frame_writer;

  localparam int AW = 10;
  localparam int N  = 1024;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          result;
  logic [16:0]   output_result;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          readout_start;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_last;
  logic          frame_done;
  logic          overrun;

  result_frame_writer #(
    .ADDR_W    (AW),
    .IN_W      (17),
    .PIX_W     (8),
    .NUM_PIXELS(N)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .result       (result),
    .output_result(output_result),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .readout_start(readout_start),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [N];
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {int addr; int data; int cyc;} wexp_t;
  typedef struct {logic [16:0] din; logic [7:0] dexp;} vec_t;

  wexp_t wq[$];
  wexp_t e;
  vec_t  vt[10];

  int exp_frame[N];
  int exp_wa  = 0;
  bit full    = 1'b0;
  bit exp_ovr = 1'b0;

  int         out_idx;
  bit         out_done;
  int         first_valid_cyc;
  int         last_cyc;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;

  function automatic int conv(input logic [16:0] v);
    int s;
    s = int'(signed'(v));
`ifdef ABS_MAG_EN
    if (s < 0) s = -s;
`else
    if (s < 0) s = 0;
`endif
    if (s > 255) s = 255;
    return s;
  endfunction

  // Write scoreboard and output-stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      if (wq.size() == 0) begin
        chk("unexpected_wr_en", 1, 0);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
        chk("wr_latency", 64'(cyc), 64'(e.cyc));
        chk("frame_done", 64'(frame_done), 64'(e.addr == N - 1));
      end
    end else if (frame_done) begin
      chk("frame_done_stray", 1, 0);
    end

    if (!n_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (out_idx >= N) begin
          chk("extra_beat", 1, 0);
        end else begin
          chk("out_data", 64'(out_data), 64'(exp_frame[out_idx]));
          chk("out_last", 64'(out_last), 64'(out_idx == N - 1));
          if (out_idx == N - 1) begin
            out_done = 1'b1;
            last_cyc = cyc;
          end
        end
        out_idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic strobe_exp(input logic [16:0] v, input int d);
    result        = 1'b1;
    output_result = v;
    if (!full) begin
      wq.push_back('{exp_wa, d, cyc + 1});
      exp_frame[exp_wa] = d;
      if (exp_wa == N - 1) begin
        full   = 1'b1;
        exp_wa = 0;
      end else begin
        exp_wa++;
      end
    end else begin
      exp_ovr = 1'b1;
    end
    @(posedge clk);
    #1;
    result = 1'b0;
  endtask

  task automatic strobe(input logic [16:0] v);
    strobe_exp(v, conv(v));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    idle(2);
    chk("wq_drained", 64'(wq.size()), 0);
  endtask

  task automatic fill_pattern();
    while (!full) strobe(17'(exp_wa % 256));
    drain();
  endtask

  task automatic run_readout(input int mode, input int abort_beat);
    int start;
    readout_start   = 1'b1;
    start           = cyc + 1;
    out_idx         = 0;
    out_done        = 1'b0;
    first_valid_cyc = -1;
    out_ready       = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    readout_start = 1'b0;
    for (int i = 0; i < 8 * N && !out_done; i++) begin
      if (abort_beat > 0 && out_idx >= abort_beat) break;
      if (mode != 0) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    if (abort_beat > 0) begin
      chk("abort_reached", 64'(out_idx >= abort_beat), 1);
      #1;
      n_rst = 1'b0;
      #1;
      chk("async_rst_wr", {wr_en, wr_addr, wr_data, frame_done}, 0);
      chk("async_rst_rd", {rd_en, rd_addr}, 0);
      chk("async_rst_out", {out_valid, out_data, out_last}, 0);
      chk("async_rst_ovr", 64'(overrun), 0);
      wq.delete();
      full    = 1'b0;
      exp_wa  = 0;
      exp_ovr = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
    end else begin
      chk("readout_done", 64'(out_done), 1);
      if (mode == 0) begin
        chk("first_valid_lat", 64'(first_valid_cyc - start), 2);
        chk("burst_len", 64'(last_cyc - first_valid_cyc), 64'(N - 1));
      end
      chk("idle_after_last", 64'(out_valid), 0);
      full   = 1'b0;
      exp_wa = 0;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    n_rst         = 1'b0;
    result        = 1'b0;
    output_result = '0;
    readout_start = 1'b0;
    out_ready     = 1'b0;

`ifdef ABS_MAG_EN
    vt[0] = '{17'h00005, 8'h05};
    vt[1] = '{17'h1FFFF, 8'h01};
    vt[2] = '{17'h00190, 8'hFF};
    vt[3] = '{17'h00000, 8'h00};
    vt[4] = '{17'h000FF, 8'hFF};
    vt[5] = '{17'h00100, 8'hFF};
    vt[6] = '{17'h1FF01, 8'hFF};
    vt[7] = '{17'h10000, 8'hFF};
    vt[8] = '{17'h0FFFF, 8'hFF};
    vt[9] = '{17'h1FFD8, 8'h28};
`else
    vt[0] = '{17'h00005, 8'h05};
    vt[1] = '{17'h1FFFF, 8'h00};
    vt[2] = '{17'h00190, 8'hFF};
    vt[3] = '{17'h00000, 8'h00};
    vt[4] = '{17'h000FF, 8'hFF};
    vt[5] = '{17'h00100, 8'hFF};
    vt[6] = '{17'h1FF01, 8'h00};
    vt[7] = '{17'h10000, 8'h00};
    vt[8] = '{17'h0FFFF, 8'hFF};
    vt[9] = '{17'h1FFD8, 8'h00};
`endif

    #3;
    chk("reset_wr", {wr_en, wr_addr, wr_data}, 0);
    chk("reset_rd", {rd_en, rd_addr}, 0);
    chk("reset_out", {out_valid, out_data, out_last}, 0);
    chk("reset_flags", {frame_done, overrun}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Conversion vectors: first three spaced out, the rest back-to-back.
    for (int i = 0; i < 10; i++) begin
      strobe_exp(vt[i].din, int'(vt[i].dexp));
      if (i < 3) idle(2);
    end
    drain();

    // Rest of the frame, with a readout_start pulse at pixel 100 that must be ignored.
    while (!full) begin
      if (exp_wa == 100) readout_start = 1'b1;
      strobe(17'(exp_wa % 256));
      readout_start = 1'b0;
      if (exp_wa > 100 && exp_wa < 106) chk("start_ignored", {rd_en, out_valid}, 0);
    end
    drain();
    chk("overrun_before", 64'(overrun), 0);

    strobe(17'h00005);
    chk("dropped_no_wr", 64'(wr_en), 0);
    chk("overrun_set", 64'(overrun), 64'(exp_ovr));

    run_readout(0, 0);

    strobe(17'h00033);
    drain();
    while (!full) strobe(17'($urandom));
    drain();
    run_readout(1, 0);
    chk("overrun_sticky", 64'(overrun), 1);

    fill_pattern();
    run_readout(0, 1000);
    strobe(17'h00044);
    drain();
    chk("overrun_after_rst", 64'(overrun), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
